multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Multi-cycle MIPS control FSM. Successor to the single-cycle opcode decoder.
- Sequences each instruction through FETCH/DECODE/EXECUTE/MEM/WB with a ready handshake to a shared instruction/data memory.
- Sits between the IR opcode field and the multi-cycle datapath (PC, IR, MDR, A/B, ALUOut registers).
- Adds wait-state handling, a memory timeout and an illegal-opcode trap.

Parameters:
- OP_W, 6, opcode width.
- ALUOP_W, 2, ALUOp width (≥2); encodings zero-extended.
- MAX_WAIT, 15, maximum consecutive not-ready cycles in any memory state before trapping (1..255).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  run enable.
- Op_i  in  OP_W  opcode from IR[31:26].
- mem_ready_i  in  1  memory completes current access this cycle.
- PCWrite_o  out  1  unconditional PC write.
- PCWriteCond_o  out  1  PC write if ALU zero.
- BranchNe_o  out  1  PC write if ALU not zero.
- IorD_o  out  1  0 = PC address, 1 = ALUOut address.
- IRWrite_o  out  1  load IR.
- MemRead_o, MemWrite_o  out  1  memory strobes.
- MemtoReg_o, RegDst_o, RegWrite_o  out  1  register-file controls.
- ALUSrcA_o  out  1  0 = PC, 1 = A.
- ALUSrcB_o  out  2  0 = B, 1 = const 4, 2 = sign-extended imm, 3 = sign-extended imm<<2.
- PCSource_o  out  2  0 = ALU, 1 = ALUOut, 2 = jump target.
- ALUOp_o  out  ALUOP_W  0 = add, 1 = sub, 2 = funct.
- state_o  out  4  current state encoding.
- illegal_o, timeout_o  out  1  sticky trap flags.

Behaviour:
- State register only. All outputs are a combinational decode of the state, plus mem_ready_i where noted. No output not listed for a state is asserted in it.
- Reset (rst_n_i = 0, asynchronous):
  - state = IDLE(0); wait counter = 0; illegal_o = timeout_o = 0.
  - All outputs 0.
- IDLE(0): go to FETCH when start_i = 1.
- FETCH(1):
  - MemRead = 1, IorD = 0, ALUSrcA = 0, ALUSrcB = 1, ALUOp = add, PCSource = 0.
  - IRWrite and PCWrite assert only in the cycle mem_ready_i = 1; that cycle goes to DECODE.
- DECODE(2):
  - ALUSrcA = 0, ALUSrcB = 3, ALUOp = add (branch target precompute).
  - Next state by Op_i: 000000 → RTEX; 001000 → IMMEX; 100011/101011 → MEMADR; 000100 → BRANCH; 000010 → JUMP; other → TRAP with illegal_o = 1.
- MEMADR(3): ALUSrcA = 1, ALUSrcB = 2, ALUOp = add. Go to MEMRD for lw, MEMWR for sw (opcode held stable in IR).
- MEMRD(4): MemRead = 1, IorD = 1; on ready → MEMWB.
- MEMWB(5): RegWrite = 1, MemtoReg = 1, RegDst = 0.
- MEMWR(6): MemWrite = 1, IorD = 1; on ready → done.
- RTEX(7): ALUSrcA = 1, ALUSrcB = 0, ALUOp = funct. → RTWB.
- RTWB(8): RegWrite = 1, RegDst = 1, MemtoReg = 0.
- IMMEX(9): ALUSrcA = 1, ALUSrcB = 2, ALUOp = add. → IMMWB.
- IMMWB(10): RegWrite = 1, RegDst = 0, MemtoReg = 0.
- BRANCH(11): ALUSrcA = 1, ALUSrcB = 0, ALUOp = sub, PCWriteCond = 1, PCSource = 1.
- JUMP(12): PCWrite = 1, PCSource = 2.
- TRAP(13):
  - All strobes 0. Held until reset; start_i ignored.
  - Flags are sticky and hold their values while in TRAP.
- Done states are MEMWB, MEMWR+ready, RTWB, IMMWB, BRANCH and JUMP. From a done state: next = FETCH if start_i = 1, else IDLE.
- Memory wait states (FETCH, MEMRD, MEMWR):
  - Counter increments each not-ready cycle and clears on state change.
  - If a not-ready cycle occurs with counter = MAX_WAIT-1 → TRAP with timeout_o = 1. MAX_WAIT not-ready cycles trap; MAX_WAIT-1 not-ready cycles followed by ready proceed normally.
  - Ready in the same cycle as the limit takes priority: the state proceeds.
- start_i deassert mid-instruction: the instruction completes, then the FSM goes to IDLE.
- Reset mid-instruction: immediate return to IDLE. The instruction is abandoned and no strobes fire.
- Instruction latency with zero memory waits: lw 5, sw 4, R/addi 4, beq 3, j 3 cycles from FETCH entry.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_BNE_EN.
- Defined: opcode 000101 (bne) decodes to BRANCH. In that state BranchNe_o = 1 and PCWriteCond_o = 0; other BRANCH outputs are as for beq.
- Undefined: 000101 is illegal → TRAP; BranchNe_o is tied to 0.

Test Plan:
- Reset, start_i = 1, Op_i = 000000, mem_ready_i always 1 → states 1,2,7,8,1. RegWrite = RegDst = 1 only in state 8. ALUOp = 2 in state 7.
- lw (100011) with mem_ready_i low for 3 cycles in FETCH and 2 in MEMRD:
  - Stays in FETCH for 4 cycles; IRWrite pulses once.
  - MemtoReg = RegWrite = 1 in state 5. Total 10 cycles.
- sw with ready never asserted in MEMWR, MAX_WAIT = 15 → TRAP after 15 cycles in MEMWR. timeout_o = 1, MemWrite = 0 thereafter; start_i toggling has no effect.
- Op_i = 111111 → DECODE → TRAP; illegal_o = 1. rst_n_i low for 1 cycle → all outputs 0, state_o = 0.
- beq then j with start_i dropped during JUMP:
  - BRANCH shows PCWriteCond = 1, ALUOp = 1, PCSource = 1.
  - JUMP shows PCWrite = 1, PCSource = 2, then IDLE.
- Op_i = 000101 with macro on → BRANCH with BranchNe_o = 1. With macro off → TRAP, illegal_o = 1.

Source files
------------

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: FETCH/DECODE/EXECUTE/MEM/WB sequencing with memory
// wait-state timeout and illegal-opcode trap. Define MULTICYCLE_CONTROL_BNE_EN to decode bne.
module multicycle_control #(
    parameter int OP_W     = 6,
    parameter int ALUOP_W  = 2,
    parameter int MAX_WAIT = 15
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               start_i,
    input  logic [OP_W-1:0]    Op_i,
    input  logic               mem_ready_i,
    output logic               PCWrite_o,
    output logic               PCWriteCond_o,
    output logic               BranchNe_o,
    output logic               IorD_o,
    output logic               IRWrite_o,
    output logic               MemRead_o,
    output logic               MemWrite_o,
    output logic               MemtoReg_o,
    output logic               RegDst_o,
    output logic               RegWrite_o,
    output logic               ALUSrcA_o,
    output logic [1:0]         ALUSrcB_o,
    output logic [1:0]         PCSource_o,
    output logic [ALUOP_W-1:0] ALUOp_o,
    output logic [3:0]         state_o,
    output logic               illegal_o,
    output logic               timeout_o
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,  S_MEMWB = 4'd5,  S_MEMWR  = 4'd6,  S_RTEX   = 4'd7,
        S_RTWB   = 4'd8,  S_IMMEX = 4'd9,  S_IMMWB  = 4'd10, S_BRANCH = 4'd11,
        S_JUMP   = 4'd12, S_TRAP  = 4'd13
    } state_e;

    localparam logic [OP_W-1:0] OP_RTYPE = OP_W'(6'b000000);
    localparam logic [OP_W-1:0] OP_ADDI  = OP_W'(6'b001000);
    localparam logic [OP_W-1:0] OP_LW    = OP_W'(6'b100011);
    localparam logic [OP_W-1:0] OP_SW    = OP_W'(6'b101011);
    localparam logic [OP_W-1:0] OP_BEQ   = OP_W'(6'b000100);
    localparam logic [OP_W-1:0] OP_J     = OP_W'(6'b000010);
`ifdef MULTICYCLE_CONTROL_BNE_EN
    localparam logic [OP_W-1:0] OP_BNE   = OP_W'(6'b000101);
`endif

    localparam logic [ALUOP_W-1:0] ALU_ADD = '0;
    localparam logic [ALUOP_W-1:0] ALU_SUB = ALUOP_W'(1);
    localparam logic [ALUOP_W-1:0] ALU_FN  = ALUOP_W'(2);
    localparam logic [7:0]         LIMIT   = 8'(MAX_WAIT - 1);

    state_e     state_q;
    logic [7:0] wcnt_q;
    logic       illegal_q, timeout_q;
    logic       mem_state, at_limit, is_bne;
    state_e     after_done;

    assign mem_state  = (state_q == S_FETCH) || (state_q == S_MEMRD) || (state_q == S_MEMWR);
    assign at_limit   = (wcnt_q == LIMIT);
    assign after_done = start_i ? S_FETCH : S_IDLE;
`ifdef MULTICYCLE_CONTROL_BNE_EN
    assign is_bne = (Op_i == OP_BNE);
`else
    assign is_bne = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            wcnt_q    <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            // Counter only survives a not-ready cycle that stays put; any move clears it.
            wcnt_q <= (mem_state && !mem_ready_i && !at_limit) ? wcnt_q + 8'd1 : 8'd0;
            case (state_q)
                S_IDLE: if (start_i) state_q <= S_FETCH;
                S_FETCH, S_MEMRD, S_MEMWR: begin
                    if (mem_ready_i) begin
                        if (state_q == S_FETCH)      state_q <= S_DECODE;
                        else if (state_q == S_MEMRD) state_q <= S_MEMWB;
                        else                         state_q <= after_done;
                    end else if (at_limit) begin
                        state_q   <= S_TRAP;
                        timeout_q <= 1'b1;
                    end
                end
                S_DECODE: begin
                    if (Op_i == OP_RTYPE)                   state_q <= S_RTEX;
                    else if (Op_i == OP_ADDI)               state_q <= S_IMMEX;
                    else if (Op_i == OP_LW || Op_i == OP_SW) state_q <= S_MEMADR;
                    else if (Op_i == OP_BEQ || is_bne)      state_q <= S_BRANCH;
                    else if (Op_i == OP_J)                  state_q <= S_JUMP;
                    else begin
                        state_q   <= S_TRAP;
                        illegal_q <= 1'b1;
                    end
                end
                S_MEMADR: state_q <= (Op_i == OP_SW) ? S_MEMWR : S_MEMRD;
                S_RTEX:   state_q <= S_RTWB;
                S_IMMEX:  state_q <= S_IMMWB;
                S_MEMWB, S_RTWB, S_IMMWB, S_BRANCH, S_JUMP: state_q <= after_done;
                S_TRAP:   state_q <= S_TRAP;
                default:  state_q <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        PCWrite_o     = 1'b0;
        PCWriteCond_o = 1'b0;
        BranchNe_o    = 1'b0;
        IorD_o        = 1'b0;
        IRWrite_o     = 1'b0;
        MemRead_o     = 1'b0;
        MemWrite_o    = 1'b0;
        MemtoReg_o    = 1'b0;
        RegDst_o      = 1'b0;
        RegWrite_o    = 1'b0;
        ALUSrcA_o     = 1'b0;
        ALUSrcB_o     = 2'd0;
        PCSource_o    = 2'd0;
        ALUOp_o       = ALU_ADD;
        case (state_q)
            S_FETCH: begin
                MemRead_o = 1'b1;
                ALUSrcB_o = 2'd1;
                IRWrite_o = mem_ready_i;
                PCWrite_o = mem_ready_i;
            end
            S_DECODE: ALUSrcB_o = 2'd3;
            S_MEMADR, S_IMMEX: begin
                ALUSrcA_o = 1'b1;
                ALUSrcB_o = 2'd2;
            end
            S_MEMRD: begin
                MemRead_o = 1'b1;
                IorD_o    = 1'b1;
            end
            S_MEMWB: begin
                RegWrite_o = 1'b1;
                MemtoReg_o = 1'b1;
            end
            S_MEMWR: begin
                MemWrite_o = 1'b1;
                IorD_o     = 1'b1;
            end
            S_RTEX: begin
                ALUSrcA_o = 1'b1;
                ALUOp_o   = ALU_FN;
            end
            S_RTWB: begin
                RegWrite_o = 1'b1;
                RegDst_o   = 1'b1;
            end
            S_IMMWB: RegWrite_o = 1'b1;
            S_BRANCH: begin
                ALUSrcA_o     = 1'b1;
                ALUOp_o       = ALU_SUB;
                PCSource_o    = 2'd1;
                PCWriteCond_o = !is_bne;
                BranchNe_o    = is_bne;
            end
            S_JUMP: begin
                PCWrite_o  = 1'b1;
                PCSource_o = 2'd2;
            end
            default: ;
        endcase
    end

    assign state_o   = state_q;
    assign illegal_o = illegal_q;
    assign timeout_o = timeout_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed self-checking bench for multicycle_control; honours MULTICYCLE_CONTROL_BNE_EN.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [5:0] Op = 6'd0;
    logic       mem_ready = 1'b0;
    logic       PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o;
    logic       MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, illegal_o, timeout_o;
    logic [1:0] ALUSrcB_o, PCSource_o, ALUOp_o;
    logic [3:0] state_o;
    logic [16:0] ctl;
    int checks = 0;
    int failures = 0;

    multicycle_control #(.OP_W(6), .ALUOP_W(2), .MAX_WAIT(15)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .Op_i(Op), .mem_ready_i(mem_ready),
        .PCWrite_o(PCWrite_o), .PCWriteCond_o(PCWriteCond_o), .BranchNe_o(BranchNe_o),
        .IorD_o(IorD_o), .IRWrite_o(IRWrite_o), .MemRead_o(MemRead_o), .MemWrite_o(MemWrite_o),
        .MemtoReg_o(MemtoReg_o), .RegDst_o(RegDst_o), .RegWrite_o(RegWrite_o),
        .ALUSrcA_o(ALUSrcA_o), .ALUSrcB_o(ALUSrcB_o), .PCSource_o(PCSource_o),
        .ALUOp_o(ALUOp_o), .state_o(state_o), .illegal_o(illegal_o), .timeout_o(timeout_o)
    );

    always #5 clk = ~clk;

    // PCWrite PCWriteCond BranchNe IorD IRWrite MemRead MemWrite MemtoReg RegDst RegWrite ALUSrcA ALUSrcB PCSource ALUOp
    assign ctl = {PCWrite_o, PCWriteCond_o, BranchNe_o, IorD_o, IRWrite_o, MemRead_o, MemWrite_o,
                  MemtoReg_o, RegDst_o, RegWrite_o, ALUSrcA_o, ALUSrcB_o, PCSource_o, ALUOp_o};

    localparam logic [16:0] C_IDLE = 17'b0_0_0_0_0_0_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_FN   = 17'b0_0_0_0_0_1_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_FR   = 17'b1_0_0_0_1_1_0_0_0_0_0_01_00_00;
    localparam logic [16:0] C_DEC  = 17'b0_0_0_0_0_0_0_0_0_0_0_11_00_00;
    localparam logic [16:0] C_ADR  = 17'b0_0_0_0_0_0_0_0_0_0_1_10_00_00;
    localparam logic [16:0] C_MRD  = 17'b0_0_0_1_0_1_0_0_0_0_0_00_00_00;
    localparam logic [16:0] C_MWB  = 17'b0_0_0_0_0_0_0_1_0_1_0_00_00_00;
    localparam logic [16:0] C_MWR  = 17'b0_0_0_1_0_0_1_0_0_0_0_00_00_00;
    localparam logic [16:0] C_RTEX = 17'b0_0_0_0_0_0_0_0_0_0_1_00_00_10;
    localparam logic [16:0] C_RTWB = 17'b0_0_0_0_0_0_0_0_1_1_0_00_00_00;
    localparam logic [16:0] C_BEQ  = 17'b0_1_0_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [16:0] C_BNE  = 17'b0_0_1_0_0_0_0_0_0_0_1_00_01_01;
    localparam logic [16:0] C_JMP  = 17'b1_0_0_0_0_0_0_0_0_0_0_00_10_00;

    localparam logic [20:0] RT_EXP [7] = '{{4'd0, C_IDLE}, {4'd1, C_FR}, {4'd2, C_DEC},
        {4'd7, C_RTEX}, {4'd8, C_RTWB}, {4'd1, C_FR}, {4'd2, C_DEC}};
    localparam logic [20:0] LW_EXP [12] = '{{4'd0, C_IDLE}, {4'd1, C_FN}, {4'd1, C_FN},
        {4'd1, C_FN}, {4'd1, C_FR}, {4'd2, C_DEC}, {4'd3, C_ADR}, {4'd4, C_MRD},
        {4'd4, C_MRD}, {4'd4, C_MRD}, {4'd5, C_MWB}, {4'd0, C_IDLE}};
    localparam logic [0:11] LW_RDY = 12'b000010000100;
    localparam logic [20:0] BJ_EXP [8] = '{{4'd0, C_IDLE}, {4'd1, C_FR}, {4'd2, C_DEC},
        {4'd11, C_BEQ}, {4'd1, C_FR}, {4'd2, C_DEC}, {4'd12, C_JMP}, {4'd0, C_IDLE}};
    localparam logic [20:0] PRE_EXP [4] = '{{4'd0, C_IDLE}, {4'd1, C_FR}, {4'd2, C_DEC},
        {4'd3, C_ADR}};

    task automatic do_reset();
        rst_n = 1'b0; start = 1'b0; mem_ready = 1'b0; Op = 6'd0;
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b1; mem_ready = 1'b1;
        #1;
        checks++;
        if ({state_o, ctl, illegal_o, timeout_o} !== 23'd0) begin
            failures++;
            $display("FAIL reset_state got=%h exp=0", {state_o, ctl, illegal_o, timeout_o});
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({state_o, ctl} !== 21'd0) begin
            failures++;
            $display("FAIL reset_held got=%h exp=0", {state_o, ctl});
        end
        rst_n = 1'b1; start = 1'b0;
    endtask

    task automatic test_rtype();
        do_reset();
        start = 1'b1; mem_ready = 1'b1; Op = 6'b000000;
        for (int i = 0; i < 7; i++) begin
            #1;
            checks++;
            if ({state_o, ctl} !== RT_EXP[i]) begin
                failures++;
                $display("FAIL rtype cyc=%0d got=%h exp=%h", i, {state_o, ctl}, RT_EXP[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_lw_waits();
        do_reset();
        Op = 6'b100011;
        for (int i = 0; i < 12; i++) begin
            start = (i == 0);
            mem_ready = LW_RDY[i];
            #1;
            checks++;
            if ({state_o, ctl} !== LW_EXP[i]) begin
                failures++;
                $display("FAIL lw_waits cyc=%0d got=%h exp=%h", i, {state_o, ctl}, LW_EXP[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_sw_timeout();
        do_reset();
        Op = 6'b101011; start = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if ({state_o, ctl} !== PRE_EXP[i]) begin
                failures++;
                $display("FAIL sw_pre cyc=%0d got=%h exp=%h", i, {state_o, ctl}, PRE_EXP[i]);
            end
            @(posedge clk); #1;
        end
        mem_ready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            #1;
            checks++;
            if ({state_o, ctl, timeout_o} !== {4'd6, C_MWR, 1'b0}) begin
                failures++;
                $display("FAIL sw_wait cyc=%0d got=%h exp=%h", i, {state_o, ctl, timeout_o},
                         {4'd6, C_MWR, 1'b0});
            end
            @(posedge clk); #1;
        end
        for (int i = 0; i < 5; i++) begin
            start = i[0];
            #1;
            checks++;
            if ({state_o, ctl, illegal_o, timeout_o} !== {4'd13, C_IDLE, 2'b01}) begin
                failures++;
                $display("FAIL sw_trap cyc=%0d got=%h exp=%h", i, {state_o, ctl, illegal_o, timeout_o},
                         {4'd13, C_IDLE, 2'b01});
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_wait_limit();
        logic [20:0] exp;
        do_reset();
        Op = 6'b101011;
        for (int i = 0; i < 34; i++) begin
            start = (i == 0);
            mem_ready = (i == 15) || (i == 32);
            if (i == 0 || i == 33)       exp = {4'd0, C_IDLE};
            else if (i < 15)             exp = {4'd1, C_FN};
            else if (i == 15)            exp = {4'd1, C_FR};
            else if (i == 16)            exp = {4'd2, C_DEC};
            else if (i == 17)            exp = {4'd3, C_ADR};
            else                         exp = {4'd6, C_MWR};
            #1;
            checks++;
            if ({state_o, ctl} !== exp) begin
                failures++;
                $display("FAIL wait_limit cyc=%0d got=%h exp=%h", i, {state_o, ctl}, exp);
            end
            @(posedge clk); #1;
        end
        checks++;
        if (timeout_o !== 1'b0) begin
            failures++;
            $display("FAIL wait_limit_flag got=%b exp=0", timeout_o);
        end
    endtask

    task automatic test_illegal();
        do_reset();
        Op = 6'b111111; start = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            start = (i < 3) ? 1'b1 : i[0];
            #1;
            checks++;
            if (i < 3 && {state_o, ctl} !== PRE_EXP[i]) begin
                failures++;
                $display("FAIL illegal_pre cyc=%0d got=%h exp=%h", i, {state_o, ctl}, PRE_EXP[i]);
            end else if (i >= 3 && {state_o, ctl, illegal_o, timeout_o} !== {4'd13, C_IDLE, 2'b10}) begin
                failures++;
                $display("FAIL illegal_trap cyc=%0d got=%h exp=%h", i,
                         {state_o, ctl, illegal_o, timeout_o}, {4'd13, C_IDLE, 2'b10});
            end
            @(posedge clk); #1;
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl, illegal_o, timeout_o} !== 23'd0) begin
            failures++;
            $display("FAIL illegal_clear got=%h exp=0", {state_o, ctl, illegal_o, timeout_o});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_reset_mid();
        do_reset();
        Op = 6'b100011; start = 1'b1; mem_ready = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
        end
        checks++;
        if ({state_o, ctl} !== {4'd4, C_MRD}) begin
            failures++;
            $display("FAIL reset_mid_pre got=%h exp=%h", {state_o, ctl}, {4'd4, C_MRD});
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl} !== 21'd0) begin
            failures++;
            $display("FAIL reset_mid got=%h exp=0", {state_o, ctl});
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic test_branch_jump();
        do_reset();
        mem_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Op = (i < 4) ? 6'b000100 : 6'b000010;
            start = (i < 6);
            #1;
            checks++;
            if ({state_o, ctl} !== BJ_EXP[i]) begin
                failures++;
                $display("FAIL branch_jump cyc=%0d got=%h exp=%h", i, {state_o, ctl}, BJ_EXP[i]);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_bne();
        logic [22:0] exp;
        do_reset();
        Op = 6'b000101; start = 1'b1; mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
        end
`ifdef MULTICYCLE_CONTROL_BNE_EN
        exp = {4'd11, C_BNE, 2'b00};
`else
        exp = {4'd13, C_IDLE, 2'b10};
`endif
        start = 1'b0;
        #1;
        checks++;
        if ({state_o, ctl, illegal_o, timeout_o} !== exp) begin
            failures++;
            $display("FAIL bne got=%h exp=%h", {state_o, ctl, illegal_o, timeout_o}, exp);
        end
    endtask

    initial begin
        test_reset();
        test_rtype();
        test_lw_waits();
        test_sw_timeout();
        test_wait_limit();
        test_illegal();
        test_reset_mid();
        test_branch_jump();
        test_bne();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
